// File: rtl/obstacle_collision_pkg.sv
// Shared definitions for the collision block: FSM state encoding and screen
// geometry constants that the obstacle generators also use.
package obstacle_collision_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ARMED    = 2'b01,
        COOLDOWN = 2'b10,
        DEAD     = 2'b11
    } state_t;

    localparam int SCREEN_END_H = 1023;
    localparam int SCREEN_END_V = 767;

endpackage

// File: rtl/obstacle_collision_hitbox_overlap.sv
// Combinational compare of one obstacle pixel against the player hit box.
module hitbox_overlap #(
    parameter int PLAYER_W = 32,
    parameter int PLAYER_H = 32
) (
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    output logic        overlap
);

    // 13-bit edges so a box near 4095 does not wrap back to 0
    logic [12:0] right_edge;
    logic [12:0] bottom_edge;
    logic        pixel_present;
    logic        in_x;
    logic        in_y;

    assign right_edge    = {1'b0, player_x} + 13'(PLAYER_W);
    assign bottom_edge   = {1'b0, player_y} + 13'(PLAYER_H);
    assign pixel_present = (obstacle_x != 12'd0) || (obstacle_y != 12'd0);
    assign in_x          = (obstacle_x >= player_x) && ({1'b0, obstacle_x} < right_edge);
    assign in_y          = (obstacle_y >= player_y) && ({1'b0, obstacle_y} < bottom_edge);
    assign overlap       = pixel_present && in_x && in_y;

endmodule

// File: rtl/obstacle_collision.sv
// Per-frame obstacle/player overlap accumulation, damage, invulnerability
// cooldown and health tracking.
module obstacle_collision
    import obstacle_collision_pkg::*;
#(
    parameter int PLAYER_W      = 32,
    parameter int PLAYER_H      = 32,
    parameter int HP_MAX        = 3,
    parameter int HIT_THRESHOLD = 4,
    parameter int INVULN_FRAMES = 60,
    parameter int FRAME_END_H   = SCREEN_END_H,
    parameter int FRAME_END_V   = SCREEN_END_V
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    input  logic        game_on,
    input  logic        menu_on,
    output logic        hit,
    output logic [3:0]  hp,
    output logic        invulnerable,
    output logic        game_over
);

    state_t      state;
    logic [15:0] ov_cnt;
    logic [15:0] frame_cnt;
    logic        overlap;
    logic        frame_end;
    logic        abort;
    logic [16:0] eval_cnt;
    logic        threshold_met;

    hitbox_overlap #(
        .PLAYER_W (PLAYER_W),
        .PLAYER_H (PLAYER_H)
    ) u_overlap (
        .obstacle_x (obstacle_x),
        .obstacle_y (obstacle_y),
        .player_x   (player_x),
        .player_y   (player_y),
        .overlap    (overlap)
    );

    assign frame_end     = (hcount_in == 12'(FRAME_END_H)) && (vcount_in == 12'(FRAME_END_V));
    assign abort         = menu_on || !game_on;
    assign eval_cnt      = {1'b0, ov_cnt} + 17'(overlap);
    assign threshold_met = eval_cnt >= 17'(HIT_THRESHOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hit          <= 1'b0;
            hp           <= 4'd0;
            invulnerable <= 1'b0;
            game_over    <= 1'b0;
            ov_cnt       <= 16'd0;
            frame_cnt    <= 16'd0;
        end else begin
            hit <= 1'b0;
            if (frame_end || state != ARMED)
                ov_cnt <= 16'd0;
            else if (overlap && ov_cnt != 16'hFFFF)
                ov_cnt <= ov_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (!abort) begin
                        state <= ARMED;
                        hp    <= 4'(HP_MAX);
                    end
                end
                ARMED: begin
                    // Abort wins over a frame-end hit in the same cycle
                    if (abort) begin
                        state  <= IDLE;
                        hp     <= 4'd0;
                        ov_cnt <= 16'd0;
                    end else if (frame_end && threshold_met && hp != 4'd0) begin
                        hit <= 1'b1;
                        hp  <= hp - 4'd1;
                        if (hp == 4'd1) begin
                            state     <= DEAD;
                            game_over <= 1'b1;
                        end else begin
                            state        <= COOLDOWN;
                            invulnerable <= 1'b1;
                            frame_cnt    <= 16'(INVULN_FRAMES);
                        end
                    end
                end
                COOLDOWN: begin
                    if (abort) begin
                        state        <= IDLE;
                        hp           <= 4'd0;
                        invulnerable <= 1'b0;
                        frame_cnt    <= 16'd0;
                    end else if (frame_end) begin
                        // A zero-length cooldown still lasts until the next frame end
                        if (frame_cnt <= 16'd1) begin
                            state        <= ARMED;
                            invulnerable <= 1'b0;
                            frame_cnt    <= 16'd0;
                        end else begin
                            frame_cnt <= frame_cnt - 16'd1;
                        end
                    end
                end
                DEAD: begin
                    if (menu_on) begin
                        state     <= IDLE;
                        game_over <= 1'b0;
                        hp        <= 4'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_collision.sv
// Randomized scoreboard bench for obstacle_collision against a frame-level
// reference model of the game rules.
module tb_obstacle_collision;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] hcount_in = '0, vcount_in = '0;
    logic [11:0] obstacle_x = '0, obstacle_y = '0;
    logic [11:0] player_x = '0, player_y = '0;
    logic        game_on = 1'b0, menu_on = 1'b0;
    logic        hit, invulnerable, game_over;
    logic [3:0]  hp;

    obstacle_collision #(
        .PLAYER_W (32), .PLAYER_H (32), .HP_MAX (3), .HIT_THRESHOLD (4),
        .INVULN_FRAMES (2), .FRAME_END_H (1023), .FRAME_END_V (767)
    ) dut (
        .clk (clk), .rst (rst),
        .hcount_in (hcount_in), .vcount_in (vcount_in),
        .obstacle_x (obstacle_x), .obstacle_y (obstacle_y),
        .player_x (player_x), .player_y (player_y),
        .game_on (game_on), .menu_on (menu_on),
        .hit (hit), .hp (hp), .invulnerable (invulnerable), .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic [3:0] hp;
        logic       inv;
        logic       go;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0 idle, 1 playing, 2 invulnerable, 3 dead
    int m_mode = 0, m_hp = 0, m_pix = 0, m_cool = 0;
    int px = 500, py = 400;
    bit gon = 0, mon = 0;

    function automatic bit touches(int ox, int oy);
        if (ox == 0 && oy == 0) return 0;
        return ox >= px && ox < px + 32 && oy >= py && oy < py + 32;
    endfunction

    task automatic cyc(input int hc, input int vc, input int ox, input int oy, input bit r);
        exp_t e;
        bit fe, ov;
        @(negedge clk);
        hcount_in = 12'(hc); vcount_in = 12'(vc);
        obstacle_x = 12'(ox); obstacle_y = 12'(oy);
        player_x = 12'(px); player_y = 12'(py);
        game_on = gon; menu_on = mon; rst = r;
        fe = (hc == 1023 && vc == 767);
        ov = touches(ox, oy);
        e.hit = 1'b0;
        if (r) begin
            m_mode = 0; m_hp = 0; m_pix = 0; m_cool = 0;
        end else if (m_mode == 0) begin
            m_pix = 0;
            if (gon && !mon) begin m_mode = 1; m_hp = 3; end
        end else if (m_mode == 1) begin
            if (mon || !gon) begin
                m_mode = 0; m_hp = 0; m_pix = 0;
            end else if (fe) begin
                if (m_pix + ov >= 4) begin
                    e.hit = 1'b1;
                    m_hp  = m_hp - 1;
                    m_mode = (m_hp == 0) ? 3 : 2;
                    m_cool = 2;
                end
                m_pix = 0;
            end else begin
                m_pix = (m_pix + ov > 65535) ? 65535 : m_pix + ov;
            end
        end else if (m_mode == 2) begin
            if (mon || !gon) begin
                m_mode = 0; m_hp = 0;
            end else if (fe) begin
                m_cool = m_cool - 1;
                if (m_cool <= 0) m_mode = 1;
            end
        end else begin
            if (mon) m_mode = 0;
        end
        e.hp  = 4'(m_hp);
        e.inv = (m_mode == 2);
        e.go  = (m_mode == 3);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cyc(5, 5, 0, 0, 0);
    endtask

    // len-1 ordinary cycles (first npix carry a vertical run of pixels), then frame end
    task automatic frame(input int len, input int npix, input int ox, input int oy, input bit abort_end);
        for (int i = 0; i < len - 1; i++)
            if (i < npix) cyc(i, 10, ox, oy + i, 0);
            else          cyc(i, 10, 0, 0, 0);
        if (abort_end) mon = 1;
        cyc(1023, 767, 0, 0, 0);
        mon = 0;
    endtask

    task automatic restart();
        mon = 1; idle();
        mon = 0; idle(); idle();
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: every registered output update is compared against the queue
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e, g;
                e = exp_q.pop_front();
                g = {hit, hp, invulnerable, game_over};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got hit=%b hp=%0d inv=%b go=%b, expected hit=%b hp=%0d inv=%b go=%b",
                             $time, g.hit, g.hp, g.inv, g.go, e.hit, e.hp, e.inv, e.go);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cyc(0, 0, 0, 0, 1);
        idle();
        chk("reset_hp", hp, 0);
        chk("reset_go", game_over, 0);

        // Start, then three quiet frames
        gon = 1; px = 500; py = 400;
        repeat (3) frame(8, 0, 0, 0, 0);
        chk("start_hp", hp, 3);

        // Four overlapping pixels -> hit
        frame(8, 4, 510, 410, 0);
        idle();
        chk("hit_pulse", hit, 1);
        chk("hit_hp", hp, 2);
        chk("hit_inv", invulnerable, 1);

        // Three pixels only, then edge pixels that must not count
        restart();
        frame(8, 3, 510, 410, 0);
        idle();
        chk("below_hp", hp, 3);
        cyc(1, 10, 510, 410, 0); cyc(2, 10, 510, 411, 0); cyc(3, 10, 510, 412, 0);
        cyc(4, 10, 532, 413, 0); cyc(5, 10, 510, 432, 0);
        cyc(1023, 767, 0, 0, 0);
        idle();
        chk("edge_hit", hit, 0);
        chk("edge_hp", hp, 3);

        // Overlap every frame: hits on frames 1, 4, 7
        restart();
        repeat (7) frame(8, 4, 510, 410, 0);
        idle();
        chk("death_go", game_over, 1);
        chk("death_hp", hp, 0);
        mon = 1; idle(); idle();
        chk("menu_go", game_over, 0);
        mon = 0; idle(); idle();

        // Menu on the frame-end cycle overrides a met threshold
        frame(8, 4, 510, 410, 1);
        idle();
        chk("abort_hit", hit, 0);
        chk("abort_hp", hp, 0);
        idle(); idle();

        // Reset in cooldown mid-frame
        frame(8, 4, 510, 410, 0);
        idle(); idle();
        cyc(3, 10, 0, 0, 1);
        idle();
        chk("rst_hp", hp, 0);
        chk("rst_inv", invulnerable, 0);
        idle();
        chk("rst_reload", hp, 3);

        // Randomized play
        for (int f = 0; f < 80; f++) begin
            int len;
            len = $urandom_range(4, 12);
            if ($urandom_range(0, 5) == 0) px = $urandom_range(3950, 4095);
            else                           px = $urandom_range(0, 4095);
            py = $urandom_range(0, 4095);
            for (int i = 0; i < len; i++) begin
                int ox, oy;
                bit r;
                gon = ($urandom_range(0, 60) != 0);
                mon = ($urandom_range(0, 40) == 0);
                r   = ($urandom_range(0, 300) == 0);
                if ($urandom_range(0, 9) < 5) begin
                    ox = px + $urandom_range(0, 40) - 4;
                    oy = py + $urandom_range(0, 40) - 4;
                    if (ox < 0) ox = 0;
                    if (ox > 4095) ox = 4095;
                    if (oy < 0) oy = 0;
                    if (oy > 4095) oy = 4095;
                end else begin
                    ox = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 4095);
                    oy = ox == 0 ? 0 : $urandom_range(0, 4095);
                end
                if (i == len - 1) cyc(1023, 767, ox, oy, r);
                else              cyc($urandom_range(0, 1022), $urandom_range(0, 800), ox, oy, r);
            end
        end
        gon = 1; mon = 0;
        idle();
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
